// File: rtl/pueo_clk_phase_tracker_if.sv
// Port bundle for pueo_clk_phase_tracker: toggle/clear in,
// phase, lock and error status out.
interface pueo_clk_phase_tracker_if #(
   parameter int PERIOD    = 4,
   parameter int ERR_WIDTH = 8
);
   localparam int PW = $clog2(PERIOD);

   logic                 toggle_i;
   logic                 err_clr_i;
   logic                 sync_o;
   logic [PW-1:0]        phase_o;
   logic                 locked_o;
   logic                 slip_o;
   logic [ERR_WIDTH-1:0] err_count_o;

   modport master (
      output toggle_i,
      output err_clr_i,
      input  sync_o,
      input  phase_o,
      input  locked_o,
      input  slip_o,
      input  err_count_o
   );

   modport slave (
      input  toggle_i,
      input  err_clr_i,
      output sync_o,
      output phase_o,
      output locked_o,
      output slip_o,
      output err_count_o
   );
endinterface

// File: rtl/pueo_clk_phase_tracker.sv
// Recovers the syncclk phase of clk from an asynchronous toggle and
// qualifies it with a HUNT/TRACK/LOCKED flywheel.
module pueo_clk_phase_tracker #(
   parameter int PERIOD      = 4,
   parameter int SYNC_STAGES = 3,
   parameter int DELAY       = 4,
   parameter int LOCK_COUNT  = 16,
   parameter int MISS_TOL    = 2,
   parameter int ERR_WIDTH   = 8
) (
   input logic                 clk,
   input logic                 rst,
   pueo_clk_phase_tracker_if.slave bus
);
   localparam int PW = $clog2(PERIOD);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_TOL + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic [PW-1:0]          ph_q, ph_d;
   state_e                 state_q, state_d;
   logic [GW-1:0]          good_q, good_d;
   logic [MW-1:0]          miss_q, miss_d;
   logic [DELAY-1:0]       sp_q;
   logic [DELAY-1:0][PW-1:0] pp_q;
   logic                   locked_q;
   logic                   slip_q, slip_d;
   logic [ERR_WIDTH-1:0]   err_q, err_d;

   logic          realign;
   logic          ph_zero;
   logic          active;
   logic [PW-1:0] cur_ph;
   logic          sync_raw;
   logic [PW-1:0] phase_raw;

   assign ph_zero = (ph_q == '0);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      miss_d  = miss_q;
      slip_d  = 1'b0;
      realign = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (edge_q) begin
               realign = 1'b1;
               good_d  = '0;
               state_d = TRACK;
            end
         end
         TRACK: begin
            unique case (1'b1)
               edge_q && ph_zero: begin
                  if (good_q == GW'(LOCK_COUNT - 1)) begin
                     good_d  = '0;
                     state_d = LOCKED;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end
               edge_q && !ph_zero: begin
                  slip_d  = 1'b1;
                  realign = 1'b1;
                  good_d  = '0;
               end
               !edge_q && ph_zero: begin
                  slip_d  = 1'b1;
                  state_d = HUNT;
               end
               default: ;
            endcase
         end
         LOCKED: begin
            // Flywheel: edges only confirm or flag, never realign.
            unique case (1'b1)
               edge_q && ph_zero: miss_d = '0;
               !edge_q && ph_zero: begin
                  slip_d = 1'b1;
                  if (miss_q == MW'(MISS_TOL - 1)) begin
                     miss_d  = '0;
                     state_d = HUNT;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
               edge_q && !ph_zero: slip_d = 1'b1;
               default: ;
            endcase
         end
         default: state_d = HUNT;
      endcase
   end

   always_comb begin
      cur_ph    = realign ? '0 : ph_q;
      active    = (state_q != HUNT) || edge_q;
      sync_raw  = active && (cur_ph == '0);
      phase_raw = active ? cur_ph : '0;
      if (realign)
         ph_d = PW'(1);
      else if (ph_q == PW'(PERIOD - 1))
         ph_d = '0;
      else
         ph_d = ph_q + 1'b1;
      // Clear wins over a coincident increment.
      if (bus.err_clr_i)
         err_d = '0;
      else if (slip_d && (err_q != '1))
         err_d = err_q + 1'b1;
      else
         err_d = err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         edge_q   <= 1'b0;
         ph_q     <= '0;
         state_q  <= HUNT;
         good_q   <= '0;
         miss_q   <= '0;
         sp_q     <= '0;
         pp_q     <= '0;
         locked_q <= 1'b0;
         slip_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         sync_q[0] <= bus.toggle_i;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         edge_q   <= sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
         ph_q     <= ph_d;
         state_q  <= state_d;
         good_q   <= good_d;
         miss_q   <= miss_d;
         sp_q[0]  <= sync_raw;
         pp_q[0]  <= phase_raw;
         for (int i = 1; i < DELAY; i++) begin
            sp_q[i] <= sp_q[i-1];
            pp_q[i] <= pp_q[i-1];
         end
         locked_q <= (state_d == LOCKED);
         slip_q   <= slip_d;
         err_q    <= err_d;
      end
   end

   assign bus.sync_o      = sp_q[DELAY-1];
   assign bus.phase_o     = pp_q[DELAY-1];
   assign bus.locked_o    = locked_q;
   assign bus.slip_o      = slip_q;
   assign bus.err_count_o = err_q;
endmodule

// File: tb/tb_pueo_clk_phase_tracker.sv
// Scoreboard bench: an integer reference model predicts every cycle,
// a monitor compares two DUTs (ERR_WIDTH 8 and 2).
module tb_pueo_clk_phase_tracker;
   localparam int P = 4;
   localparam int S = 3;
   localparam int D = 2;
   localparam int L = 4;
   localparam int M = 2;

   typedef struct {
      logic       sync;
      logic [1:0] phase;
      logic       locked;
      logic       slip;
      logic [7:0] e8;
      logic [7:0] e2;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tog = 1'b0;
   logic clr = 1'b0;

   int total = 0;
   int bad = 0;
   int ncyc = 0;

   exp_t sb[$];

   string mode = "HUNT";
   int    ph = 0, good = 0, miss = 0, e8 = 0, e2 = 0;
   bit    er = 1'b0;
   bit    tog_v = 1'b0;
   bit    hist[$];
   bit    pq[$];
   int    phq[$];

   pueo_clk_phase_tracker_if #(.PERIOD(P), .ERR_WIDTH(8)) b8 ();
   pueo_clk_phase_tracker_if #(.PERIOD(P), .ERR_WIDTH(2)) b2 ();

   assign b8.toggle_i  = tog;
   assign b8.err_clr_i = clr;
   assign b2.toggle_i  = tog;
   assign b2.err_clr_i = clr;

   pueo_clk_phase_tracker #(
      .PERIOD(P), .SYNC_STAGES(S), .DELAY(D),
      .LOCK_COUNT(L), .MISS_TOL(M), .ERR_WIDTH(8)
   ) dut8 (
      .clk(clk), .rst(rst), .bus(b8)
   );

   pueo_clk_phase_tracker #(
      .PERIOD(P), .SYNC_STAGES(S), .DELAY(D),
      .LOCK_COUNT(L), .MISS_TOL(M), .ERR_WIDTH(2)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(b2)
   );

   always #5 clk = ~clk;

   function automatic bit h(int i);
      return (i < 0) ? 1'b0 : hist[i];
   endfunction

   task automatic model_reset();
      mode = "HUNT";
      ph = 0; good = 0; miss = 0; e8 = 0; e2 = 0;
      er = 1'b0;
      hist.delete();
      pq.delete();
      phq.delete();
      for (int i = 0; i < D; i++) begin
         pq.push_back(1'b0);
         phq.push_back(0);
      end
   endtask

   task automatic model_step(output exp_t x, output bit sl);
      bit    e, re, act;
      int    cur, k;
      string nm;
      e = er; re = 0; sl = 0; nm = mode;
      if (mode == "HUNT") begin
         if (e) begin re = 1; good = 0; nm = "TRACK"; end
      end else if (mode == "TRACK") begin
         if (e && ph == 0) begin
            good++;
            if (good == L) begin good = 0; nm = "LOCKED"; end
         end else if (e) begin
            sl = 1; re = 1; good = 0;
         end else if (ph == 0) begin
            sl = 1; nm = "HUNT";
         end
      end else begin
         if (ph == 0 && e) miss = 0;
         else if (ph == 0) begin
            sl = 1; miss++;
            if (miss == M) begin miss = 0; nm = "HUNT"; end
         end else if (e) sl = 1;
      end
      cur = re ? 0 : ph;
      act = (mode != "HUNT") || e;
      pq.push_front(act && cur == 0);
      phq.push_front(act ? cur : 0);
      x.sync  = pq[D-1];
      x.phase = 2'(phq[D-1]);
      void'(pq.pop_back());
      void'(phq.pop_back());
      ph = re ? 1 : (ph + 1) % P;
      mode = nm;
      k = hist.size();
      er = h(k - S + 1) ^ h(k - S);
      hist.push_back(tog_v);
      x.locked = (mode == "LOCKED");
      x.slip   = sl;
   endtask

   task automatic cyc(bit flip, bit r = 0, bit c = 0, bit c_on_slip = 0);
      exp_t x;
      bit   sl;
      @(negedge clk);
      if (flip) tog_v = ~tog_v;
      if (r) begin
         model_reset();
         x = '{1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0};
      end else begin
         model_step(x, sl);
         c = c | (c_on_slip & sl);
         if (c) begin
            e8 = 0; e2 = 0;
         end else if (sl) begin
            if (e8 < 255) e8++;
            if (e2 < 3) e2++;
         end
         x.e8 = 8'(e8);
         x.e2 = 8'(e2);
      end
      rst = r;
      tog = tog_v;
      clr = c;
      sb.push_back(x);
   endtask

   task automatic edges(int n, bit c_on_slip = 0);
      repeat (n) begin
         cyc(1, 0, 0, c_on_slip);
         repeat (P - 1) cyc(0, 0, 0, c_on_slip);
      end
   endtask

   task automatic gap(int n, bit c_on_slip = 0);
      repeat (n) cyc(0, 0, 0, c_on_slip);
   endtask

   task automatic chk(string nm, logic s, logic [1:0] p, logic l,
                      logic sl, logic [7:0] e, exp_t x, logic [7:0] xe);
      total++;
      if (s !== x.sync || p !== x.phase || l !== x.locked ||
          sl !== x.slip || e !== xe) begin
         bad++;
         $display("FAIL %s cyc=%0d got s=%0b ph=%0d lk=%0b sl=%0b err=%0d want s=%0b ph=%0d lk=%0b sl=%0b err=%0d",
                  nm, ncyc, s, p, l, sl, e,
                  x.sync, x.phase, x.locked, x.slip, xe);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         ncyc++;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("w8", b8.sync_o, b8.phase_o, b8.locked_o, b8.slip_o,
                b8.err_count_o, x, x.e8);
            chk("w2", b2.sync_o, b2.phase_o, b2.locked_o, b2.slip_o,
                {6'd0, b2.err_count_o}, x, x.e2);
         end
      end
   end

   initial begin : stim
      int gph;
      model_reset();
      repeat (3) cyc(0, 1);
      // steady grid, lock
      edges(12);
      // one missing toggle, then two
      gap(4);
      edges(6);
      gap(8);
      edges(12);
      // one late edge, back on grid
      cyc(0); cyc(1); cyc(0); cyc(0);
      edges(6);
      // grid shift during TRACK
      cyc(0, 1);
      edges(3);
      gap(2);
      edges(10);
      // reset while locked, pipe must stay quiet
      cyc(0, 1);
      gap(12);
      edges(8);
      // pile up errors to saturate the narrow counter
      repeat (4) begin
         cyc(0);
         edges(3);
      end
      edges(8);
      // clear coincident with error
      gap(12, 1);
      edges(8);
      // randomized grid with jitter, drops, clears, resets
      gph = 0;
      repeat (3000) begin
         bit f, c, r;
         gph = (gph + 1) % P;
         if ($urandom_range(0, 99) == 0) gph = (gph + 1) % P;
         f = (gph == 0 && $urandom_range(0, 11) != 0) ||
             ($urandom_range(0, 59) == 0);
         c = ($urandom_range(0, 79) == 0);
         r = ($urandom_range(0, 699) == 0);
         cyc(f, r, c);
      end
      @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
